// File: rtl/ula_pkg.sv
// Shared ULA definitions: sequencer states, counter sizing helper and
// operation encoding for the multi-cycle adder/subtractor.
package ula_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // A single-chunk configuration still needs a one-bit counter.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/somador_bloco.sv
// CHUNK-bit combinational ripple slice; also exposes the carry into its MSB
// so the sequencer can derive signed overflow on the final chunk.
module somador_bloco #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout  = c[CHUNK];
  assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/somador_sequencial.sv
// Multi-cycle WIDTH-bit adder/subtractor that walks CHUNK bits per clock
// through one shared ripple slice, with start/busy/done handshake and flags.
//
// state | meaning
// IDLE  | waiting for start; last result held on outputs
// RUN   | one chunk per edge into the accumulator; outputs unchanged
// DONE  | results just updated, done pulse; start here chains a new op
module somador_sequencial
  import ula_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int               NCHUNK = WIDTH / CHUNK;
  localparam int               CW     = cnt_width(NCHUNK);
  localparam logic [CW-1:0]    LAST   = CW'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] MASK   = WIDTH'({CHUNK{1'b1}});

  if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
    $error("somador_sequencial: WIDTH must be a non-zero multiple of CHUNK");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic [CHUNK-1:0] sl_a, sl_b, sl_s;
  logic             sl_cout, sl_cmsb;
  int               base;

  always_comb begin
    base = int'(cnt_q) * CHUNK;
    sl_a = CHUNK'(op_a_q >> base);
    sl_b = CHUNK'(op_b_q >> base);
  end

  somador_bloco #(
    .CHUNK (CHUNK)
  ) u_bloco (
    .a     (sl_a),
    .b     (sl_b),
    .cin   (carry_q),
    .s     (sl_s),
    .cout  (sl_cout),
    .c_msb (sl_cmsb)
  );

  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;

    case (state_q)
      IDLE: ;
      RUN: begin
        acc_d   = (acc_q & ~(MASK << base)) | (WIDTH'(sl_s) << base);
        carry_d = sl_cout;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          cnt_d   = '0;
          s_d     = acc_d;
          cout_d  = sl_cout;
          ovf_d   = sl_cmsb ^ sl_cout;
          zero_d  = (acc_d == '0);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Subtraction is A + ~B + 1: invert B here and seed the carry with sub.
    if (start && (state_q != RUN)) begin
      state_d = RUN;
      op_a_d  = a;
      op_b_d  = b ^ {WIDTH{sub == OP_SUB}};
      carry_d = (sub == OP_SUB);
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_a_q  <= '0;
      op_b_q  <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign s    = s_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;

endmodule
